// File: rtl/hazard_pkg.sv
// Shared types and constants for the mMIPS hazard scoreboard.
// Entry struct, branch opcodes and branch-bubble limit.
package hazard_pkg;

  localparam int SB_AW  = 8;
  localparam int BR_MAX = 7;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] rd;
    logic             load;
  } sb_entry_t;

  function automatic logic is_branch_op(
    input logic [5:0] op
  );
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage side of the hazard unit: instruction info in,
// pipeline controls and stall count out.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5
);

  logic              enable;
  logic              dmem_wait;
  logic              imem_wait;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_wr_reg;
  logic              id_is_load;
  logic              id_is_branch;
  logic              pc_write;
  logic              ifid_write;
  logic              bubble;
  logic              pipe_en;
  logic              imem_en;
  logic [31:0]       stall_cycles;

  modport master (
    output enable, dmem_wait, imem_wait,
    output id_rs, id_rt,
    output id_rs_used, id_rt_used,
    output id_wr_en, id_wr_reg,
    output id_is_load, id_is_branch,
    input  pc_write, ifid_write, bubble,
    input  pipe_en, imem_en, stall_cycles
  );

  modport slave (
    input  enable, dmem_wait, imem_wait,
    input  id_rs, id_rt,
    input  id_rs_used, id_rt_used,
    input  id_wr_en, id_wr_reg,
    input  id_is_load, id_is_branch,
    output pc_write, ifid_write, bubble,
    output pipe_en, imem_en, stall_cycles
  );

endinterface

// File: rtl/hazard_sb_pipe.sv
// DEPTH-entry destination tag shift register (entry 0 = EX)
// with per-entry source match flags.
module hazard_sb_pipe
  import hazard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_i,
  input  sb_entry_t         new_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              rs_used_i,
  input  logic              rt_used_i,
  output logic [DEPTH-1:0]  rs_hit_o,
  output logic [DEPTH-1:0]  rt_hit_o,
  output logic              ld0_o
);

  sb_entry_t ent_q [DEPTH];
  sb_entry_t ent_d [DEPTH];

  logic [SB_AW-1:0] rs_x;
  logic [SB_AW-1:0] rt_x;
  logic             rs_ok;
  logic             rt_ok;

  assign rs_x  = SB_AW'(rs_i);
  assign rt_x  = SB_AW'(rt_i);
  assign rs_ok = rs_used_i && (rs_i != '0);
  assign rt_ok = rt_used_i && (rt_i != '0);
  assign ld0_o = ent_q[0].valid && ent_q[0].load;

  always_comb begin
    ent_d = ent_q;
    if (shift_i) begin
      ent_d[0] = new_i;
      for (int i = 1; i < DEPTH; i++) begin
        ent_d[i] = ent_q[i-1];
      end
    end
  end

  always_comb begin
    rs_hit_o = '0;
    rt_hit_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs_hit_o[i] = rs_ok && ent_q[i].valid
                 && (ent_q[i].rd == rs_x);
      rt_hit_o[i] = rt_ok && ent_q[i].valid
                 && (ent_q[i].rd == rt_x);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      ent_q <= ent_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard unit beside ID: stalls, branch
// bubbles, memory waits and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int FWD        = 0,
  parameter int BR_BUBBLES = 1
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave hz
);

  localparam logic [2:0] BR_INIT =
    3'((BR_BUBBLES > BR_MAX) ? BR_MAX : BR_BUBBLES);

  logic [2:0]       br_q, br_d;
  logic [31:0]      stall_q, stall_d;
  logic [DEPTH-1:0] rs_hit, rt_hit;
  logic             ld0;
  logic             hit_any, hit0, hazard;
  logic             stall_inc, issue;
  logic             pc_w, ifid_w, bub, pen, ien;
  sb_entry_t        new_ent;

  hazard_sb_pipe #(
    .DEPTH  (DEPTH),
    .REG_AW (REG_AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .shift_i   (pen),
    .new_i     (new_ent),
    .rs_i      (hz.id_rs),
    .rt_i      (hz.id_rt),
    .rs_used_i (hz.id_rs_used),
    .rt_used_i (hz.id_rt_used),
    .rs_hit_o  (rs_hit),
    .rt_hit_o  (rt_hit),
    .ld0_o     (ld0)
  );

  assign hit_any = |(rs_hit | rt_hit);
  assign hit0    = rs_hit[0] | rt_hit[0];
  // With forwarding only a load in EX cannot supply ID in time
  assign hazard  = (FWD != 0) ? (hit0 && ld0) : hit_any;

  always_comb begin
    pc_w      = 1'b0;
    ifid_w    = 1'b0;
    bub       = 1'b0;
    pen       = 1'b0;
    ien       = 1'b0;
    stall_inc = 1'b0;
    issue     = 1'b0;
    if (rst || !hz.enable) begin
      pen = 1'b0;
    end else if (hz.dmem_wait) begin
      stall_inc = 1'b1;
    end else if (hz.imem_wait) begin
      ien       = 1'b1;
      stall_inc = 1'b1;
    end else if ((br_q != 3'd0) || hazard) begin
      pen       = 1'b1;
      bub       = 1'b1;
      stall_inc = 1'b1;
    end else begin
      pen    = 1'b1;
      pc_w   = 1'b1;
      ifid_w = 1'b1;
      ien    = 1'b1;
      issue  = 1'b1;
    end
  end

  always_comb begin
    new_ent.valid = issue && hz.id_wr_en
                 && (hz.id_wr_reg != '0);
    new_ent.rd    = SB_AW'(hz.id_wr_reg);
    new_ent.load  = issue && hz.id_is_load;
  end

  always_comb begin
    br_d = br_q;
    if (issue && hz.id_is_branch) begin
      br_d = BR_INIT;
    end else if (pen && (br_q != 3'd0)) begin
      br_d = br_q - 3'd1;
    end
  end

  assign stall_d = (stall_inc && (stall_q != '1))
                 ? stall_q + 32'd1 : stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q    <= 3'd0;
      stall_q <= 32'd0;
    end else begin
      br_q    <= br_d;
      stall_q <= stall_d;
    end
  end

  assign hz.pc_write     = pc_w;
  assign hz.ifid_write   = ifid_w;
  assign hz.bubble       = bub;
  assign hz.pipe_en      = pen;
  assign hz.imem_en      = ien;
  assign hz.stall_cycles = stall_q;

endmodule
